// File: rtl/reg_status_table_if.sv
// Issue-stage bus for the register status table: rename requests, CDB
// broadcasts, two operand read ports and the busy count.
//
// Handshake: ren_valid and cdb_valid are single-cycle qualifiers with no
// back-pressure (the table is always ready), each accepted at the rising
// edge on which it is high. Read ports are purely combinational.
interface reg_status_table_if #(
  parameter int ADDR_W = 6,
  parameter int TAG_W  = 8,
  parameter int WORD_W = 32
);
  logic              flush;
  logic              ren_valid;
  logic [ADDR_W-1:0] ren_reg;
  logic [TAG_W-1:0]  ren_tag;
  logic              cdb_valid;
  logic [TAG_W-1:0]  cdb_tag;
  logic [WORD_W-1:0] cdb_data;
  logic [ADDR_W-1:0] rd0_reg;
  logic [ADDR_W-1:0] rd1_reg;
  logic              rd0_ready;
  logic              rd1_ready;
  logic [TAG_W-1:0]  rd0_tag;
  logic [TAG_W-1:0]  rd1_tag;
  logic [WORD_W-1:0] rd0_val;
  logic [WORD_W-1:0] rd1_val;
  logic [ADDR_W:0]   busy_cnt;

  modport master (
    output flush, ren_valid, ren_reg, ren_tag, cdb_valid, cdb_tag, cdb_data,
           rd0_reg, rd1_reg,
    input  rd0_ready, rd1_ready, rd0_tag, rd1_tag, rd0_val, rd1_val, busy_cnt
  );

  modport slave (
    input  flush, ren_valid, ren_reg, ren_tag, cdb_valid, cdb_tag, cdb_data,
           rd0_reg, rd1_reg,
    output rd0_ready, rd1_ready, rd0_tag, rd1_tag, rd0_val, rd1_val, busy_cnt
  );
endinterface

// File: rtl/reg_status_table.sv
// Register status / rename table for a Tomasulo-style issue stage.
// Holds one producer tag and one value per architectural register, with
// two combinational read ports that bypass a same-cycle CDB broadcast.
module reg_status_table #(
  parameter int                 NUM_REGS    = 64,
  parameter int                 ADDR_W      = 6,
  parameter int                 TAG_W       = 8,
  parameter int                 WORD_W      = 32,
  parameter logic [TAG_W-1:0]   READY_TAG   = 8'h7F,
  parameter bit                 ZERO_REG_EN = 1'b1
) (
  input logic               clk,
  input logic               rst,
  reg_status_table_if.slave bus
);

  // Register count in index width + 1 so out-of-range indices compare cleanly.
  localparam logic [ADDR_W:0] NUM_REGS_W = (ADDR_W+1)'(NUM_REGS);

  logic [TAG_W-1:0]  tag_q [NUM_REGS];
  logic [TAG_W-1:0]  tag_d [NUM_REGS];
  logic [WORD_W-1:0] val_q [NUM_REGS];
  logic [WORD_W-1:0] val_d [NUM_REGS];
  logic [ADDR_W:0]   busy_cnt_q;
  logic [ADDR_W:0]   busy_cnt_d;

  // A broadcast carrying READY_TAG never matches anything.
  logic cdb_live;
  logic ren_live;
  assign cdb_live = bus.cdb_valid && (bus.cdb_tag != READY_TAG);
  assign ren_live = bus.ren_valid && !bus.flush && (bus.ren_tag != READY_TAG);

  // Next-state per register: flush > rename > CDB for the tag; the value
  // follows any CDB match regardless of what happens to the tag.
  always_comb begin
    busy_cnt_d = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      logic hard_zero;
      logic cdb_hit;
      logic ren_hit;
      hard_zero = ZERO_REG_EN && (i == 0);
      cdb_hit   = cdb_live && (tag_q[i] == bus.cdb_tag) && !hard_zero;
      ren_hit   = ren_live && (bus.ren_reg == ADDR_W'(i)) && !hard_zero;
      val_d[i]  = cdb_hit ? bus.cdb_data : val_q[i];
      if (bus.flush)  tag_d[i] = READY_TAG;
      else if (ren_hit) tag_d[i] = bus.ren_tag;
      else if (cdb_hit) tag_d[i] = READY_TAG;
      else              tag_d[i] = tag_q[i];
      if (tag_d[i] != READY_TAG) busy_cnt_d = busy_cnt_d + (ADDR_W+1)'(1);
    end
  end

  // State registers; reset returns every entry to ready with value 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        tag_q[i] <= READY_TAG;
        val_q[i] <= '0;
      end
      busy_cnt_q <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        tag_q[i] <= tag_d[i];
        val_q[i] <= val_d[i];
      end
      busy_cnt_q <= busy_cnt_d;
    end
  end

  logic [ADDR_W-1:0] rd_reg   [2];
  logic              rd_ready [2];
  logic [TAG_W-1:0]  rd_tag   [2];
  logic [WORD_W-1:0] rd_val   [2];

  assign rd_reg[0] = bus.rd0_reg;
  assign rd_reg[1] = bus.rd1_reg;

  // Read ports from pre-edge state: CDB bypass first, then stored state.
  // Reset, register 0 and out-of-range indices read as ready with value 0.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rd_ready[p] = 1'b1;
      rd_tag[p]   = READY_TAG;
      rd_val[p]   = '0;
      if (!rst && ({1'b0, rd_reg[p]} < NUM_REGS_W) &&
          !(ZERO_REG_EN && (rd_reg[p] == '0))) begin
        if (cdb_live && (tag_q[rd_reg[p]] == bus.cdb_tag)) begin
          rd_val[p] = bus.cdb_data;
        end else if (tag_q[rd_reg[p]] == READY_TAG) begin
          rd_val[p] = val_q[rd_reg[p]];
        end else begin
          rd_ready[p] = 1'b0;
          rd_tag[p]   = tag_q[rd_reg[p]];
        end
      end
    end
  end

  assign bus.rd0_ready = rd_ready[0];
  assign bus.rd0_tag   = rd_tag[0];
  assign bus.rd0_val   = rd_val[0];
  assign bus.rd1_ready = rd_ready[1];
  assign bus.rd1_tag   = rd_tag[1];
  assign bus.rd1_val   = rd_val[1];
  assign bus.busy_cnt  = busy_cnt_q;

endmodule

// File: tb/tb_reg_status_table.sv
// Self-checking bench for reg_status_table: directed test-plan steps
// followed by randomized traffic, checked against a behavioural model.
module tb_reg_status_table;
  localparam int         NUM_REGS = 64;
  localparam int         ADDR_W   = 6;
  localparam int         TAG_W    = 8;
  localparam int         WORD_W   = 32;
  localparam logic [7:0] RT       = 8'h7F;

  // Clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  reg_status_table_if #(.ADDR_W(ADDR_W), .TAG_W(TAG_W), .WORD_W(WORD_W)) bus ();

  reg_status_table #(
    .NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W), .TAG_W(TAG_W), .WORD_W(WORD_W),
    .READY_TAG(RT), .ZERO_REG_EN(1'b1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: one tag and one value per register
  logic [7:0]  m_tag [NUM_REGS];
  logic [31:0] m_val [NUM_REGS];

  // Last observations, for directed test-plan checks
  logic [31:0] obs_rdy0, obs_tag0, obs_val0, obs_rdy1, obs_tag1, obs_val1, obs_busy;

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  // What a read of register r must return given the model and current inputs
  task automatic model_read(input logic r_rst, input logic [5:0] r, input logic cv,
                            input logic [7:0] ct, input logic [31:0] cd,
                            output logic [31:0] rdy, output logic [31:0] tg,
                            output logic [31:0] v);
    rdy = 1; tg = 32'(RT); v = 0;
    if (r_rst || r == 0) return;
    if (cv && ct != RT && m_tag[r] == ct) v = cd;
    else if (m_tag[r] == RT) v = m_val[r];
    else begin rdy = 0; tg = 32'(m_tag[r]); end
  endtask

  function automatic int model_busy();
    int n = 0;
    for (int i = 0; i < NUM_REGS; i++) if (m_tag[i] != RT) n++;
    return n;
  endfunction

  // Driver: apply one cycle of inputs, check reads before the edge and
  // busy_cnt after it, and advance the model.
  task automatic step(input logic r_rst, input logic fl, input logic rv,
                      input logic [5:0] rr, input logic [7:0] rt,
                      input logic cv, input logic [7:0] ct, input logic [31:0] cd,
                      input logic [5:0] a0, input logic [5:0] a1);
    logic [31:0] e_rdy, e_tg, e_v;
    logic [7:0]  nt [NUM_REGS];
    logic [31:0] nv [NUM_REGS];
    @(negedge clk);
    rst = r_rst;
    bus.flush = fl; bus.ren_valid = rv; bus.ren_reg = rr; bus.ren_tag = rt;
    bus.cdb_valid = cv; bus.cdb_tag = ct; bus.cdb_data = cd;
    bus.rd0_reg = a0; bus.rd1_reg = a1;
    #1;
    obs_rdy0 = 32'(bus.rd0_ready); obs_tag0 = 32'(bus.rd0_tag); obs_val0 = bus.rd0_val;
    obs_rdy1 = 32'(bus.rd1_ready); obs_tag1 = 32'(bus.rd1_tag); obs_val1 = bus.rd1_val;
    model_read(r_rst, a0, cv, ct, cd, e_rdy, e_tg, e_v);
    check("rd0_ready", obs_rdy0, e_rdy);
    check("rd0_tag", obs_tag0, e_tg);
    check("rd0_val", obs_val0, e_v);
    model_read(r_rst, a1, cv, ct, cd, e_rdy, e_tg, e_v);
    check("rd1_ready", obs_rdy1, e_rdy);
    check("rd1_tag", obs_tag1, e_tg);
    check("rd1_val", obs_val1, e_v);
    // Spec rules applied to the whole table at once
    for (int i = 0; i < NUM_REGS; i++) begin
      logic hit;
      hit = cv && ct != RT && i != 0 && m_tag[i] == ct;
      nv[i] = hit ? cd : m_val[i];
      nt[i] = m_tag[i];
      if (hit) nt[i] = RT;
      if (rv && rt != RT && i != 0 && int'(rr) == i) nt[i] = rt;
      if (fl) nt[i] = RT;
      if (r_rst) begin nt[i] = RT; nv[i] = 0; end
    end
    m_tag = nt;
    m_val = nv;
    @(posedge clk);
    #1;
    obs_busy = 32'(bus.busy_cnt);
    check("busy_cnt", obs_busy, 32'(model_busy()));
  endtask

  task automatic idle(input logic [5:0] a0, input logic [5:0] a1);
    step(0, 0, 0, 0, 0, 0, 0, 0, a0, a1);
  endtask

  task automatic rename(input logic [5:0] rr, input logic [7:0] rt);
    step(0, 0, 1, rr, rt, 0, 0, 0, rr, 0);
  endtask

  initial begin
    rst = 1'b1;
    bus.flush = 0; bus.ren_valid = 0; bus.ren_reg = 0; bus.ren_tag = 0;
    bus.cdb_valid = 0; bus.cdb_tag = 0; bus.cdb_data = 0;
    bus.rd0_reg = 0; bus.rd1_reg = 0;
    for (int i = 0; i < NUM_REGS; i++) begin m_tag[i] = 8'h00; m_val[i] = 32'hDEAD; end

    // 1: reset, then r5 / r63 read ready with value 0
    step(1, 0, 0, 0, 0, 0, 0, 0, 5, 63);
    step(1, 0, 0, 0, 0, 0, 0, 0, 5, 63);
    idle(5, 63);
    check("tp1_r5_ready", obs_rdy0, 1);
    check("tp1_r63_tag", obs_tag1, 32'h7F);
    check("tp1_r63_val", obs_val1, 0);
    check("tp1_busy", obs_busy, 0);

    // 2: rename r3 -> tag 2, then CDB tag 2 with bypass
    rename(3, 2);
    check("tp2_rename_invisible", obs_rdy0, 1);
    idle(3, 3);
    check("tp2_r3_pending", obs_rdy0, 0);
    check("tp2_r3_tag", obs_tag0, 2);
    check("tp2_busy1", obs_busy, 1);
    step(0, 0, 0, 0, 0, 1, 2, 32'h1234, 3, 3);
    check("tp2_bypass_ready", obs_rdy0, 1);
    check("tp2_bypass_val", obs_val0, 32'h1234);
    check("tp2_busy0", obs_busy, 0);
    idle(3, 0);
    check("tp2_stored_val", obs_val0, 32'h1234);

    // 3: two registers waiting on one tag, released together
    rename(4, 5);
    rename(9, 5);
    check("tp3_busy2", obs_busy, 2);
    step(0, 0, 0, 0, 0, 1, 5, 32'hAA, 4, 9);
    check("tp3_busy0", obs_busy, 0);
    idle(4, 9);
    check("tp3_r4_val", obs_val0, 32'hAA);
    check("tp3_r9_val", obs_val1, 32'hAA);

    // 4: rename wins over a same-cycle CDB on the same register
    rename(7, 1);
    step(0, 0, 1, 7, 3, 1, 1, 32'h55, 7, 7);
    check("tp4_busy", obs_busy, 1);
    idle(7, 7);
    check("tp4_r7_ready", obs_rdy0, 0);
    check("tp4_r7_tag", obs_tag1, 3);

    // 5: flush drops a same-cycle rename
    rename(1, 1);
    rename(2, 2);
    rename(3, 3);
    step(0, 1, 1, 10, 4, 0, 0, 0, 1, 10);
    check("tp5_busy", obs_busy, 0);
    idle(10, 1);
    check("tp5_r10_ready", obs_rdy0, 1);
    check("tp5_r1_ready", obs_rdy1, 1);

    // 6: r0 and READY_TAG renames ignored; reset mid-stream
    rename(0, 6);
    rename(11, RT);
    idle(0, 11);
    check("tp6_r0_val", obs_val0, 0);
    check("tp6_busy", obs_busy, 0);
    rename(20, 2);
    rename(21, 3);
    step(1, 0, 1, 22, 4, 0, 0, 0, 20, 21);
    check("tp6_rst_forced", obs_rdy0, 1);
    check("tp6_rst_busy", obs_busy, 0);
    idle(20, 21);

    // Randomized traffic on a small register/tag window to force collisions
    for (int n = 0; n < 600; n++) begin
      logic        r_rst, fl, rv, cv;
      logic [5:0]  rr, a0, a1;
      logic [7:0]  rt, ct;
      logic [31:0] cd;
      r_rst = ($urandom_range(0, 99) == 0);
      fl    = ($urandom_range(0, 29) == 0);
      rv    = ($urandom_range(0, 2) != 0);
      cv    = ($urandom_range(0, 1) != 0);
      rr    = ($urandom_range(0, 7) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(0, 15));
      rt    = ($urandom_range(0, 15) == 0) ? RT : 8'($urandom_range(0, 7));
      ct    = ($urandom_range(0, 1) != 0) ? m_tag[$urandom_range(0, 15)] : 8'($urandom_range(0, 7));
      cd    = $urandom;
      a0    = 6'($urandom_range(0, 15));
      a1    = ($urandom_range(0, 3) == 0) ? a0 : 6'($urandom_range(0, 63));
      step(r_rst, fl, rv, rr, rt, cv, ct, cd, a0, a1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
